// File: rtl/pio_in_debounce.sv
// pio_in_debounce: Avalon-MM input PIO with per-bit synchroniser, debouncer,
// edge capture (R/W1C) and maskable level interrupt.
module pio_in_debounce #(
    parameter int WIDTH           = 8,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int EDGE_TYPE       = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);
    localparam int CW = DEBOUNCE_CYCLES > 0 ? $clog2(DEBOUNCE_CYCLES + 1) : 1;

    logic [SYNC_STAGES*WIDTH-1:0] chain;
    logic [WIDTH-1:0]             sync;
    logic [WIDTH-1:0]             stable;
    logic [WIDTH-1:0]             stable_d;
    logic [WIDTH-1:0]             mask;
    logic [WIDTH-1:0]             edgecap;
    logic [WIDTH-1:0]             set;
    logic [WIDTH-1:0]             clr;
    logic [31:0]                  rd_mux;
    logic                         wr;
    logic                         unused_writedata;

    assign unused_writedata = ^writedata;

    // Newest sample enters at the bottom; the top WIDTH bits are the last stage.
    always_ff @(posedge clk)
        chain <= reset ? '0 : {chain[(SYNC_STAGES-1)*WIDTH-1:0], in_port};

    assign sync = chain[SYNC_STAGES*WIDTH-1 -: WIDTH];

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_bypass
            always_ff @(posedge clk)
                stable <= reset ? '0 : sync;
        end else begin : g_debounce
            logic [CW-1:0] cnt [WIDTH];
            always_ff @(posedge clk)
                for (int i = 0; i < WIDTH; i++)
                    if (reset) begin
                        cnt[i]    <= '0;
                        stable[i] <= 1'b0;
                    end else if (sync[i] == stable[i])
                        cnt[i] <= '0;
                    else if (cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
                        stable[i] <= sync[i];
                        cnt[i]    <= '0;
                    end else
                        cnt[i] <= cnt[i] + CW'(1);
        end
    endgenerate

    always_comb begin
        wr     = chipselect & ~write_n;
        set    = EDGE_TYPE == 0 ? stable & ~stable_d :
                 EDGE_TYPE == 1 ? ~stable & stable_d : stable ^ stable_d;
        clr    = (wr && address == 2'd3) ? writedata[WIDTH-1:0] : '0;
        rd_mux = address == 2'd0 ? 32'(stable)  :
                 address == 2'd2 ? 32'(mask)    :
                 address == 2'd3 ? 32'(edgecap) : 32'd0;
    end

    // A new edge overrides a simultaneous W1C of the same bit.
    always_ff @(posedge clk)
        if (reset) begin
            stable_d <= '0;
            mask     <= '0;
            edgecap  <= '0;
            readdata <= '0;
        end else begin
            stable_d <= stable;
            if (wr && address == 2'd2)
                mask <= writedata[WIDTH-1:0];
            edgecap  <= (edgecap & ~clr) | set;
            readdata <= rd_mux;
        end

    assign irq = |(edgecap & mask);
endmodule

// File: tb/tb_pio_in_debounce.sv
// tb_pio_in_debounce: directed bench; a rising-edge and a falling-edge instance
// share clock, reset and bus, each with its own input bank.
module tb_pio_in_debounce;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [1:0]  address = 2'd0;
    logic [31:0] writedata = '0;
    logic [3:0]  in0 = 4'h0;
    logic [3:0]  in1 = 4'h4;
    logic [31:0] rd0, rd1;
    logic        irq0, irq1;
    int          n_checks = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    pio_in_debounce #(.WIDTH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(0)) u_rise (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in0),
        .readdata(rd0), .irq(irq0)
    );

    pio_in_debounce #(.WIDTH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(1)) u_fall (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in1),
        .readdata(rd1), .irq(irq1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic rd(input logic [1:0] a);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b1;
        @(negedge clk);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b0;
        writedata  = d;
        @(negedge clk);
        write_n    = 1'b1;
        chipselect = 1'b0;
    endtask

    initial begin
        tick(3);
        for (int a = 0; a < 4; a++) begin
            rd(2'(a));
            check($sformatf("reset_rd0_a%0d", a), rd0, 0);
            check($sformatf("reset_irq0_a%0d", a), {31'd0, irq0}, 0);
            check($sformatf("reset_rd1_a%0d", a), rd1, 0);
        end
        reset = 1'b0;
        tick(10);
        rd(2'd0);
        check("fall_data_after_reset", rd1, 32'h4);
        check("rise_data_idle", rd0, 0);
        rd(2'd3);
        check("fall_rise_not_captured", rd1, 0);

        // clean change: DATA visible on the 7th negedge after driving
        address = 2'd0;
        in0 = 4'h5;
        for (int i = 1; i <= 7; i++) begin
            @(negedge clk);
            check($sformatf("data_latency_%0d", i), rd0, i == 7 ? 32'h5 : 32'h0);
        end
        rd(2'd3);
        check("edgecap_clean", rd0, 32'h5);
        check("irq_masked", {31'd0, irq0}, 0);

        in0 = 4'h0;
        tick(10);
        wr(2'd3, 32'hF);
        rd(2'd3);
        check("edgecap_cleared_all", rd0, 0);

        // 3-cycle glitch is rejected, 4-cycle pulse is accepted
        in0 = 4'h1;
        tick(3);
        in0 = 4'h0;
        tick(10);
        rd(2'd0);
        check("glitch_data", rd0, 0);
        rd(2'd3);
        check("glitch_edgecap", rd0, 0);
        in0 = 4'h1;
        tick(4);
        in0 = 4'h0;
        tick(12);
        rd(2'd3);
        check("pulse4_edgecap", rd0, 32'h1);
        check("pulse4_irq_masked", {31'd0, irq0}, 0);
        wr(2'd3, 32'h1);

        wr(2'd2, 32'h1);
        check("mask_no_edge_irq", {31'd0, irq0}, 0);
        rd(2'd2);
        check("mask_readback", rd0, 32'h1);
        in0 = 4'h1;
        tick(10);
        check("irq_on_edge", {31'd0, irq0}, 1);
        rd(2'd3);
        check("edgecap_irq", rd0, 32'h1);
        wr(2'd3, 32'h1);
        check("irq_after_w1c", {31'd0, irq0}, 0);
        rd(2'd3);
        check("edgecap_after_w1c", rd0, 0);

        // W1C lands on the same edge that sets EDGECAP[0]
        in0 = 4'h0;
        tick(10);
        in0 = 4'h1;
        tick(6);
        wr(2'd3, 32'h1);
        check("collision_irq", {31'd0, irq0}, 1);
        rd(2'd3);
        check("collision_edgecap", rd0, 32'h1);
        wr(2'd3, 32'h1);
        check("collision_cleanup_irq", {31'd0, irq0}, 0);

        in1 = 4'h0;
        tick(10);
        rd(2'd3);
        check("fall_edgecap", rd1, 32'h4);
        check("fall_irq_masked_bit", {31'd0, irq1}, 0);

        // reset two counts into a debounce, then re-debounce from zero
        in1 = 4'h4;
        tick(4);
        reset = 1'b1;
        tick(1);
        check("midreset_rd1", rd1, 0);
        check("midreset_irq0", {31'd0, irq0}, 0);
        check("midreset_irq1", {31'd0, irq1}, 0);
        tick(1);
        reset = 1'b0;
        address = 2'd0;
        for (int i = 1; i <= 7; i++) begin
            @(negedge clk);
            check($sformatf("redebounce_%0d", i), rd1, i == 7 ? 32'h4 : 32'h0);
        end
        rd(2'd2);
        check("mask0_after_reset", rd0, 0);
        check("mask1_after_reset", rd1, 0);
        rd(2'd3);
        check("held_high_rise_captured", rd0, 32'h1);
        check("held_high_no_irq", {31'd0, irq0}, 0);
        check("fall_edgecap_after_reset", rd1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
